// File: rtl/neuron_core_pkg.sv
// Shared definitions for the neuron core address-decode path.
// Holds the decoder FSM state encoding and the default region indices
// used by the Wishbone-facing decoder.
package neuron_core_pkg;

  // Decoder FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_WAIT = WAIT,
    ST_ACK  = ACK,
    ST_ERR  = ERR
  } state_e;

  // Default region map of the neuron core
  localparam int unsigned REG_SYNAP = 0;
  localparam int unsigned REG_PARAM = 1;
  localparam int unsigned REG_SPIKE = 2;

  // Wait-state counter width (WAIT_CYCLES range 0..15)
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/neuron_region_onehot.sv
// Combinational region-select decoder: SEL_W index -> 2**SEL_W one-hot,
// gated by REGION_MASK so an unmapped region yields an all-zero vector.
// Ports:
//   sel_idx   in   SEL_W         region index taken from the address
//   region_c  out  2**SEL_W      one-hot (or zero) region select
module neuron_region_onehot #(
  parameter int unsigned           SEL_W       = 2,
  parameter logic [(2**SEL_W)-1:0] REGION_MASK = '1
) (
  input  logic [SEL_W-1:0]      sel_idx,
  output logic [(2**SEL_W)-1:0] region_c
);

  // At most one bit set, and only if the region is mapped
  always_comb begin
    region_c          = '0;
    region_c[sel_idx] = REGION_MASK[sel_idx];
  end

endmodule

// File: rtl/neuron_addr_decoder_seq.sv
// Registered Wishbone address decoder for the neuron core. Latches a
// request, decodes the region-select field into a one-hot select, a
// parameter index and a word offset, and answers with ack (or err) after
// WAIT_CYCLES wait states.
// Optional feature macro: NEURON_DEC_ERR_EN -- when defined, accesses to an
// unmapped region end with a wbs_err_o pulse; otherwise they are acked with
// no region selected and wbs_err_o is tied low.
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   wbs_cyc_i/stb_i/we_i/adr_i  Wishbone slave request
//   wbs_ack_o, wbs_err_o        one-cycle response pulses
//   region_sel_o                one-hot region select (held for the access)
//   param_num_o                 parameter index (parameter region only)
//   word_off_o                  word offset, adr[OFF_W+1:2]
//   we_o                        latched write enable
//   busy_o                      high whenever the FSM is not idle
module neuron_addr_decoder_seq
  import neuron_core_pkg::*;
#(
  parameter int unsigned           ADDR_W       = 32,
  parameter int unsigned           SEL_LSB      = 13,
  parameter int unsigned           SEL_W        = 2,
  parameter int unsigned           PARAM_REGION = REG_PARAM,
  parameter int unsigned           PARAM_LSB    = 4,
  parameter int unsigned           PARAM_W      = 5,
  parameter int unsigned           OFF_W        = 13,
  parameter logic [(2**SEL_W)-1:0] REGION_MASK  = 4'b0111,
  parameter int unsigned           WAIT_CYCLES  = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [ADDR_W-1:0]        wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic                     wbs_err_o,
  output logic [(2**SEL_W)-1:0]    region_sel_o,
  output logic [PARAM_W-1:0]       param_num_o,
  output logic [OFF_W-1:0]         word_off_o,
  output logic                     we_o,
  output logic                     busy_o
);

  localparam int unsigned NUM_REGIONS = 2**SEL_W;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ack_q, ack_d;
  logic [NUM_REGIONS-1:0] sel_q, sel_d;
  logic [PARAM_W-1:0]     param_q, param_d;
  logic [OFF_W-1:0]       off_q, off_d;
  logic                   we_q, we_d;
  logic                   busy_q, busy_d;
`ifdef NEURON_DEC_ERR_EN
  logic                   err_q, err_d;
`endif

  logic [NUM_REGIONS-1:0] region_c;
  logic                   adr_unused;

  // Only the select, parameter and offset fields are decoded
  assign adr_unused = ^wbs_adr_i;

  neuron_region_onehot #(
    .SEL_W       (SEL_W),
    .REGION_MASK (REGION_MASK)
  ) u_onehot (
    .sel_idx  (wbs_adr_i[SEL_LSB +: SEL_W]),
    .region_c (region_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    sel_d   = sel_q;
    param_d = param_q;
    off_d   = off_q;
    we_d    = we_q;
`ifdef NEURON_DEC_ERR_EN
    err_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          sel_d   = region_c;
          param_d = region_c[PARAM_REGION] ? wbs_adr_i[PARAM_LSB +: PARAM_W] : '0;
          off_d   = wbs_adr_i[2 +: OFF_W];
          we_d    = wbs_we_i;
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          // Master abandoned the cycle: drop silently
          state_d = ST_IDLE;
          sel_d   = '0;
          param_d = '0;
          off_d   = '0;
          we_d    = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (sel_q != '0) begin
          // A latched non-zero select means the region is mapped
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else begin
          state_d = ST_ERR;
`ifdef NEURON_DEC_ERR_EN
          err_d   = 1'b1;
`else
          ack_d   = 1'b1;
`endif
        end
      end
      ST_ACK, ST_ERR: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        param_d = '0;
        off_d   = '0;
        we_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      sel_q   <= '0;
      param_q <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      param_q <= param_d;
      off_q   <= off_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end

`ifdef NEURON_DEC_ERR_EN
  // Error pulse register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign wbs_err_o = err_q;
`else
  assign wbs_err_o = 1'b0;
`endif

  assign wbs_ack_o    = ack_q;
  assign region_sel_o = sel_q;
  assign param_num_o  = param_q;
  assign word_off_o   = off_q;
  assign we_o         = we_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_neuron_addr_decoder_seq.sv
// Scoreboard bench for neuron_addr_decoder_seq: a driver issues directed and
// random Wishbone requests and pushes the expected response; a monitor pops
// and compares whenever ack or err appears.
module tb_neuron_addr_decoder_seq;

  localparam int TB_W = 1;

  typedef struct {
    logic [3:0]  sel;
    logic [4:0]  param;
    logic [12:0] off;
    logic        we;
    logic        is_err;
    int          edge_no;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic        ack, err, we_out, busy;
  logic [3:0]  sel;
  logic [4:0]  param;
  logic [12:0] off;

  int   n_chk   = 0;
  int   n_pass  = 0;
  int   cyc_cnt = 0;
  logic prev_ack = 1'b0;
  exp_t sb[$];

  neuron_addr_decoder_seq #(
    .WAIT_CYCLES (TB_W)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_adr_i    (adr),
    .wbs_ack_o    (ack),
    .wbs_err_o    (err),
    .region_sel_o (sel),
    .param_num_o  (param),
    .word_off_o   (off),
    .we_o         (we_out),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
  endtask

  task automatic fail_now(input string msg);
    n_chk++;
    $display("FAIL %s (cycle %0d)", msg, cyc_cnt);
  endtask

  // Reference: regions 0..2 mapped, region 1 carries a parameter number
  function automatic exp_t model(input logic [31:0] a, input logic w, input int sample_edge);
    exp_t r;
    int   region;
    bit   mapped;
    region   = int'((a / 32'd8192) % 32'd4);
    mapped   = (region != 3);
    r.sel    = mapped ? 4'(1 << region) : 4'd0;
    r.param  = (mapped && region == 1) ? 5'((a / 32'd16) % 32'd32) : 5'd0;
    r.off    = 13'((a / 32'd4) % 32'd8192);
    r.we     = w;
`ifdef NEURON_DEC_ERR_EN
    r.is_err = !mapped;
`else
    r.is_err = 1'b0;
`endif
    r.edge_no = sample_edge + 1 + TB_W;
    return r;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_sel"}, 32'(sel), 0);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each response
  always @(negedge clk) begin
    exp_t got_e;
    if (rst === 1'b0) begin
      check("inv_onehot0", 32'($onehot0(sel)), 1);
      check("inv_ack_err_excl", 32'(ack & err), 0);
      check("ack_single_pulse", 32'(ack & prev_ack), 0);
      if (ack || err) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_response with empty scoreboard");
        end else begin
          got_e = sb.pop_front();
          check("resp_sel", 32'(sel), 32'(got_e.sel));
          check("resp_param", 32'(param), 32'(got_e.param));
          check("resp_off", 32'(off), 32'(got_e.off));
          check("resp_we", 32'(we_out), 32'(got_e.we));
          check("resp_err", 32'(err), 32'(got_e.is_err));
          check("resp_ack", 32'(ack), 32'(!got_e.is_err));
          check("resp_latency_edge", 32'(cyc_cnt), 32'(got_e.edge_no));
          check("resp_busy", 32'(busy), 1);
        end
      end
    end
    prev_ack = ack;
  end

  // abort_j < 0: normal access; otherwise drop cyc after edge E+abort_j
  task automatic issue(input logic [31:0] a, input logic w, input int abort_j);
    int  e0;
    bit  got;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w;
    e0 = cyc_cnt;
    if (abort_j < 0) sb.push_back(model(a, w, e0 + 1));
    @(posedge clk);
    if (abort_j >= 0) begin
      repeat (abort_j + 1) @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      check_quiet("abort");
    end else begin
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (ack || err) begin
          got = 1'b1;
          break;
        end
      end
      cyc = 1'b0; stb = 1'b0;
      if (!got) begin
        fail_now("response_timeout");
        void'(sb.pop_front());
      end else begin
        @(negedge clk);
        check_quiet("post_resp");
      end
    end
  endtask

  initial begin
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle bus after reset
    repeat (3) begin
      @(negedge clk);
      check_quiet("reset_idle");
      check("reset_we", 32'(we_out), 0);
      check("reset_param", 32'(param), 0);
      check("reset_off", 32'(off), 0);
    end

    issue(32'h0000_0000, 1'b0, -1);
    issue(32'h0000_2150, 1'b1, -1);
    issue(32'h0000_6000, 1'b0, -1);
    issue(32'h0000_4000, 1'b0, TB_W);
    issue(32'h0000_4000, 1'b1, 0);

    // Reset during WAIT, between clock edges
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = 32'h0000_3008; we = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_quiet("midrst");
    check("midrst_we", 32'(we_out), 0);
    check("midrst_param", 32'(param), 0);
    check("midrst_off", 32'(off), 0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    #1 rst = 1'b0;
    issue(32'h0000_2234, 1'b0, -1);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      int unsigned ab;
      logic [31:0] ra;
      logic        rw;
      ra = $urandom;
      rw = 1'($urandom);
      ab = $urandom_range(5, 0);
      if (ab == 0) issue(ra, rw, int'($urandom_range(TB_W, 0)));
      else         issue(ra, rw, -1);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout (cycle %0d)", cyc_cnt);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/neuron_addr_decoder_seq.md
Name: neuron_addr_decoder_seq

Overview:
Registered, parametrised successor to the neuron core's combinational address decoder. Sits between the Wishbone slave port and the synapse-matrix, parameter and spike-out storage. Latches the request address and decodes a configurable select field into a one-hot region select, parameter index and word offset. Generates the Wishbone ack/err handshake with programmable wait states.

Parameters:
ADDR_W, 32, Wishbone address width.
SEL_LSB, 13, LSB of the region-select field.
SEL_W, 2, width of the region-select field; NUM_REGIONS = 2**SEL_W.
PARAM_REGION, 1, region index whose accesses carry a parameter number.
PARAM_LSB, 4, LSB of the parameter-number field.
PARAM_W, 5, parameter-number width.
OFF_W, 13, word-offset width, taken from addr[OFF_W+1:2].
REGION_MASK, 4'b0111, bit r = 1 means region r is mapped; width NUM_REGIONS.
WAIT_CYCLES, 1, wait states inserted before ack; range 0..15.

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  asynchronous active-high reset
wbs_cyc_i  in  1  bus cycle valid
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  write enable, latched and forwarded
wbs_adr_i  in  ADDR_W  byte address
wbs_ack_o  out  1  transfer acknowledge, one-cycle pulse
wbs_err_o  out  1  error pulse for an unmapped region (only driven with the feature)
region_sel_o  out  NUM_REGIONS  one-hot region select, held for the whole transaction
param_num_o  out  PARAM_W  parameter index, valid only when region_sel_o[PARAM_REGION]
word_off_o  out  OFF_W  word offset within the region
we_o  out  1  latched write enable
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous and active-high. Every output goes to 0, state goes to IDLE, wait counter goes to 0.
- States are IDLE, WAIT, ACK and ERR.
- IDLE:
  - Triggers on a clock edge where cyc&stb=1.
  - On that edge: latch the address fields, set we_o, set region_sel_o bit addr[SEL_LSB+SEL_W-1:SEL_LSB] if that region is mapped, and load the counter with WAIT_CYCLES. Next state is WAIT.
  - param_num_o = addr[PARAM_LSB+PARAM_W-1:PARAM_LSB] only for PARAM_REGION, otherwise 0.
- WAIT:
  - Counter nonzero: decrement the counter.
  - Counter zero, mapped region: go to ACK and assert wbs_ack_o.
  - Counter zero, unmapped region: go to ERR.
- ACK: wbs_ack_o is high for exactly this one cycle. Next state is IDLE. Clear region_sel_o, param_num_o, word_off_o and we_o.
- Latency: strobe sampled at edge E → ack high in the cycle after edge E+1+WAIT_CYCLES. WAIT_CYCLES=0 gives ack 2 cycles after the sampling edge.
- No back-to-back requests: a new request can be sampled no earlier than the edge after ACK/ERR ends.
- Abort: if cyc_i falls in WAIT, go to IDLE at the next edge. No ack or err is generated, and all selects are cleared.
- Invariants:
  - region_sel_o is never multi-hot.
  - region_sel_o is all-zero for an unmapped region.
  - ack and err are never high together.
- Reset mid-transaction: immediate return to IDLE; no ack.

Optional Feature:
Macro NEURON_DEC_ERR_EN.
- Defined: in ERR, wbs_err_o pulses for one cycle, then the block returns to IDLE.
- Undefined: ERR asserts wbs_ack_o instead, so unmapped accesses complete silently with no select. wbs_err_o is tied to 0.

Decomposition:
Shared package neuron_core_pkg holds:
- state encoding localparams (IDLE=2'd0, WAIT=2'd1, ACK=2'd2, ERR=2'd3);
- default region indices: REG_SYNAP=0, REG_PARAM=1, REG_SPIKE=2.

One natural sub-module is neuron_region_onehot. It is a combinational SEL_W-to-NUM_REGIONS one-hot decoder that applies the REGION_MASK gating.

Test Plan:
1. Reset, then an idle bus → all outputs 0, busy_o=0.
2. Read addr 0x0000_0000, WAIT_CYCLES=1 → region_sel_o=4'b0001; ack high in the 3rd cycle after the sampling edge; busy_o falls after ack.
3. Write addr 0x0000_2150 → region_sel_o=4'b0010, param_num_o=5'd21, we_o=1, single ack pulse.
4. Addr 0x0000_6000 (region 3, unmapped):
   - with NEURON_DEC_ERR_EN: err=1 for one cycle, ack=0, region_sel_o=0;
   - without it: ack=1, err=0.
5. Addr 0x0000_4000, cyc_i dropped during WAIT with WAIT_CYCLES=3 → no ack or err; busy_o=0 and sel=0 the next cycle.
6. wb_rst_i asserted mid-WAIT with no clock edge → outputs 0 immediately; a new request afterwards is acked normally.
